// File: rtl/note_sequencer_mc.sv
// rtl/note_sequencer_mc.sv - multi-voice pattern sequencer with a shared, time-multiplexed sync-ROM fetch engine
module note_sequencer_mc #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 5,
  parameter int LENGTH = 15
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_note_stb,
  input  logic                                              i_play,
  input  logic                                              i_restart,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)+IDX_W-1:0] o_rom_addr,
  input  logic [15:0]                                       i_rom_data,
  output logic [NUM_CH*6-1:0]                               o_note,
  output logic [NUM_CH*4-1:0]                               o_instrument,
  output logic [NUM_CH-1:0]                                 o_new_note,
  output logic                                              o_busy,
  output logic                                              o_overrun
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx [NUM_CH];
  logic [4:0]        cnt [NUM_CH];
  logic [4:0]        len [NUM_CH];
  logic [NUM_CH-1:0] pending, expire, avail, clr;
  logic [CH_W-1:0]   cur, sel;
  logic              sel_vld, tick, load_addr, data_we;
  logic [IDX_W-1:0]  idx_adv;

  assign tick = i_note_stb & i_play & ~i_restart;

  always_comb begin
    expire = '0;
    for (int k = 0; k < NUM_CH; k++)
      expire[k] = tick && (cnt[k] == len[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sel_vld) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  state_nxt = sel_vld ? S_ADDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (i_restart) state_nxt = S_IDLE;
  end

  // The channel finishing in DATA is excluded so the engine can chain straight into the next one.
  always_comb begin
    avail = pending;
    if (state == S_DATA) avail[cur] = 1'b0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (avail[k]) begin
        sel     = CH_W'(k);
        sel_vld = i_play;
      end
    end
    load_addr = (state == S_IDLE || state == S_DATA) && sel_vld && !i_restart;
    data_we   = (state == S_DATA) && !i_restart;
    clr       = '0;
    if (data_we) clr[cur] = 1'b1;
    idx_adv   = (i_rom_data[15] || idx[cur] == IDX_W'(LENGTH)) ? '0 : idx[cur] + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rom_addr   <= '0;
      o_note       <= '0;
      o_instrument <= '0;
      o_new_note   <= '0;
      o_busy       <= 1'b0;
      o_overrun    <= 1'b0;
      pending      <= '0;
      cur          <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        idx[k] <= '0;
        cnt[k] <= '0;
        len[k] <= '0;
      end
    end else if (i_restart) begin
      o_new_note <= '0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
      pending    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        idx[k] <= '0;
        cnt[k] <= '0;
        len[k] <= '0;
      end
    end else begin
      o_new_note <= '0;
      o_overrun  <= tick && (|pending);
      o_busy     <= (state != S_IDLE) || (|pending) || tick;
      if (load_addr) begin
        o_rom_addr <= {sel, idx[sel]};
        cur        <= sel;
      end
      if (data_we) begin
        o_note[int'(cur)*6 +: 6]       <= i_rom_data[5:0];
        o_instrument[int'(cur)*4 +: 4] <= i_rom_data[14:11];
        len[cur]                       <= i_rom_data[10:6];
        idx[cur]                       <= idx_adv;
        o_new_note[cur]                <= 1'b1;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (expire[k])  cnt[k] <= '0;
        else if (tick)  cnt[k] <= cnt[k] + 1'b1;
      end
      // A new request in the same cycle as its fetch completes must survive.
      pending <= (pending & ~clr) | expire;
    end
  end
endmodule
